logic_gates_checker: RTL and testbench

//  Synthesizable on-board self-test engine for the 2-input gate block (outputs oAnd/oOr/oNot).

---
 rtl/gate_test_pkg.sv | 29 ++
 rtl/gate_golden_model.sv | 12 +
 rtl/logic_gates_checker.sv | 136 +++++++++++++
 tb/tb_logic_gates_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and golden behaviour for the 2-input gate block self-test.
package gate_test_pkg;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned VEC_W       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic g_and;
        logic g_or;
        logic g_not;
    } gate_out_t;

    function automatic gate_out_t gate_golden(input logic a, input logic b);
        gate_out_t g;
        g.g_and = a & b;
        g.g_or  = a | b;
        g.g_not = ~a;
        return g;
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational expected outputs of the gate block for a given (A,B).
module gate_golden_model
    import gate_test_pkg::*;
(
    input  logic      a_i,
    input  logic      b_i,
    output gate_out_t golden_c_o
);

    assign golden_c_o = gate_golden(a_i, b_i);

endmodule

// File: rtl/logic_gates_checker.sv
// On-board self-test engine: walks all four (A,B) vectors through the gate block,
// compares its outputs against golden values and reports mismatch statistics.
module logic_gates_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 4
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    output logic                   oA,
    output logic                   oB,
    input  logic                   iAnd,
    input  logic                   iOr,
    input  logic                   iNot,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oPass,
    output logic [ERR_W-1:0]       oErrCnt,
    output logic [NUM_VECTORS-1:0] oFailVec
);

    localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned SUM_W   = ERR_W + 2;
    localparam int unsigned ERR_MAX = (1 << ERR_W) - 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [VEC_W-1:0]         idx_q;
    logic                     a_q;
    logic                     b_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     pass_q;
    logic [ERR_W-1:0]         err_q;
    logic [NUM_VECTORS-1:0]   fail_q;

    gate_out_t                golden_c;
    gate_out_t                observed_c;
    gate_out_t                diff_c;
    logic [1:0]               mism_c;
    logic [SUM_W-1:0]         sum_c;
    logic [ERR_W-1:0]         err_d;

    // Golden reference follows what is actually being driven onto the gate block.
    gate_golden_model u_golden (
        .a_i        (a_q),
        .b_i        (b_q),
        .golden_c_o (golden_c)
    );

    assign observed_c = {iAnd, iOr, iNot};
    assign diff_c     = golden_c ^ observed_c;
    assign mism_c     = 2'(diff_c.g_and) + 2'(diff_c.g_or) + 2'(diff_c.g_not);

    // Saturating accumulate of mismatched bits; never wraps.
    assign sum_c = SUM_W'(err_q) + SUM_W'(mism_c);
    assign err_d = (sum_c > SUM_W'(ERR_MAX)) ? ERR_W'(ERR_MAX) : ERR_W'(sum_c);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        err_q   <= '0;
                        fail_q  <= '0;
                        pass_q  <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    a_q     <= idx_q[1];
                    b_q     <= idx_q[0];
                    cnt_q   <= '0;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    err_q <= err_d;
                    if (|diff_c) begin
                        fail_q[idx_q] <= 1'b1;
                    end
                    if (idx_q == LAST_VEC) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        pass_q  <= (err_d == '0);
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + VEC_W'(1);
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign oA       = a_q;
    assign oB       = b_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oPass    = pass_q;
    assign oErrCnt  = err_q;
    assign oFailVec = fail_q;

endmodule

// File: tb/tb_logic_gates_checker.sv
// Directed bench: checker looped back through a fault-injectable gate model.
module tb_logic_gates_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       a, b;
    logic       g_and, g_or, g_not;
    logic       busy, done, pass;
    logic [3:0] err;
    logic [3:0] failv;

    logic       start2;
    logic       a2, b2;
    logic       busy2, done2, pass2;
    logic [1:0] err2;
    logic [3:0] failv2;

    // 0 = healthy, 1 = And stuck-at-0, 2 = Not wired as A, 3 = all outputs inverted
    int fault;

    int total;
    int bad;

    logic_gates_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) dut (
        .iClk(clk), .iRst(rst), .iStart(start),
        .oA(a), .oB(b),
        .iAnd(g_and), .iOr(g_or), .iNot(g_not),
        .oBusy(busy), .oDone(done), .oPass(pass),
        .oErrCnt(err), .oFailVec(failv)
    );

    logic_gates_checker #(.SETTLE_CYCLES(4), .ERR_W(2)) dut2 (
        .iClk(clk), .iRst(rst), .iStart(start2),
        .oA(a2), .oB(b2),
        .iAnd(~(a2 & b2)), .iOr(~(a2 | b2)), .iNot(a2),
        .oBusy(busy2), .oDone(done2), .oPass(pass2),
        .oErrCnt(err2), .oFailVec(failv2)
    );

    always_comb begin
        g_and = (fault == 1) ? 1'b0 : (a & b);
        g_or  = a | b;
        g_not = (fault == 2) ? a : ~a;
        if (fault == 3) begin
            g_and = ~(a & b);
            g_or  = ~(a | b);
            g_not = a;
        end
    end

    always #5 clk = ~clk;

    // Pulse start for one edge and return the cycle oDone was seen (-1 on timeout).
    task automatic run_wait(output int done_cyc);
        done_cyc = -1;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (a !== 1'b0)     begin bad++; $display("FAIL reset_a got=%b exp=0", a); end
        total++; if (b !== 1'b0)     begin bad++; $display("FAIL reset_b got=%b exp=0", b); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (pass !== 1'b0)  begin bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
        total++; if (err !== 4'd0)   begin bad++; $display("FAIL reset_err got=%0d exp=0", err); end
        total++; if (failv !== 4'd0) begin bad++; $display("FAIL reset_failvec got=%b exp=0000", failv); end
    endtask

    task automatic test_clean();
        int dc;
        fault = 0;
        run_wait(dc);
        total++; if (dc != 25)        begin bad++; $display("FAIL clean_latency got=%0d exp=25", dc); end
        total++; if (pass !== 1'b1)   begin bad++; $display("FAIL clean_pass got=%b exp=1", pass); end
        total++; if (err !== 4'd0)    begin bad++; $display("FAIL clean_err got=%0d exp=0", err); end
        total++; if (failv !== 4'd0)  begin bad++; $display("FAIL clean_failvec got=%b exp=0000", failv); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL clean_busy_done got=%b exp=0", busy); end
        total++; if ({a, b} !== 2'b00) begin bad++; $display("FAIL clean_ab_done got=%b exp=00", {a, b}); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL clean_done_width got=%b exp=0", done); end
        total++; if (pass !== 1'b1)   begin bad++; $display("FAIL clean_pass_hold got=%b exp=1", pass); end
    endtask

    task automatic test_and_stuck();
        int dc;
        fault = 1;
        run_wait(dc);
        total++; if (dc != 25)           begin bad++; $display("FAIL and_latency got=%0d exp=25", dc); end
        total++; if (err !== 4'd1)       begin bad++; $display("FAIL and_err got=%0d exp=1", err); end
        total++; if (failv !== 4'b1000)  begin bad++; $display("FAIL and_failvec got=%b exp=1000", failv); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL and_pass got=%b exp=0", pass); end
        @(posedge clk); #1;
    endtask

    task automatic test_not_wired();
        int dc;
        fault = 2;
        run_wait(dc);
        total++; if (err !== 4'd4)       begin bad++; $display("FAIL not_err got=%0d exp=4", err); end
        total++; if (failv !== 4'b1111)  begin bad++; $display("FAIL not_failvec got=%b exp=1111", failv); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL not_pass got=%b exp=0", pass); end
        @(posedge clk); #1;
        fault = 0;
    endtask

    task automatic test_saturate();
        int dc;
        dc = -1;
        start2 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (done2) begin
                dc = c;
                break;
            end
        end
        total++; if (dc != 25)           begin bad++; $display("FAIL sat_latency got=%0d exp=25", dc); end
        total++; if (err2 !== 2'd3)      begin bad++; $display("FAIL sat_err got=%0d exp=3", err2); end
        total++; if (failv2 !== 4'b1111) begin bad++; $display("FAIL sat_failvec got=%b exp=1111", failv2); end
        total++; if (pass2 !== 1'b0)     begin bad++; $display("FAIL sat_pass got=%b exp=0", pass2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dc;
        int seen;
        fault = 3;
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        // Cycle 15 is inside vector 2 SETTLE; vectors 0 and 1 each lost 3 bits.
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
        total++; if (err !== 4'd6)       begin bad++; $display("FAIL mid_err got=%0d exp=6", err); end
        total++; if (failv !== 4'b0011)  begin bad++; $display("FAIL mid_failvec got=%b exp=0011", failv); end
        total++; if ({a, b} !== 2'b10)   begin bad++; $display("FAIL mid_ab got=%b exp=10", {a, b}); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fault = 0;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (err !== 4'd0)       begin bad++; $display("FAIL rstmid_err got=%0d exp=0", err); end
        total++; if (failv !== 4'd0)     begin bad++; $display("FAIL rstmid_failvec got=%b exp=0000", failv); end
        total++; if ({a, b} !== 2'b00)   begin bad++; $display("FAIL rstmid_ab got=%b exp=00", {a, b}); end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen != 0)          begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
        run_wait(dc);
        total++; if (dc != 25)           begin bad++; $display("FAIL rstmid_rerun_latency got=%0d exp=25", dc); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL rstmid_rerun_pass got=%b exp=1", pass); end
        @(posedge clk); #1;
    endtask

    task automatic test_restart_ignored();
        int dc;
        fault = 1;
        dc = -1;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = (c == 10);
            if (done) begin
                dc = c;
                break;
            end
        end
        start = 1'b0;
        total++; if (dc != 25)           begin bad++; $display("FAIL repulse_latency got=%0d exp=25", dc); end
        total++; if (failv !== 4'b1000)  begin bad++; $display("FAIL repulse_failvec got=%b exp=1000", failv); end
        @(posedge clk); #1;
        fault = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Stale results from the previous run must already be gone at cycle 1.
        total++; if (failv !== 4'd0)     begin bad++; $display("FAIL rerun_failvec_cleared got=%b exp=0000", failv); end
        total++; if (err !== 4'd0)       begin bad++; $display("FAIL rerun_err_cleared got=%0d exp=0", err); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL rerun_pass_during got=%b exp=0", pass); end
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL rerun_busy got=%b exp=1", busy); end
        dc = -1;
        for (int c = 2; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                dc = c;
                break;
            end
        end
        total++; if (dc != 25)           begin bad++; $display("FAIL rerun_latency got=%0d exp=25", dc); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL rerun_pass got=%b exp=1", pass); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int dc;
        fault = 0;
        dc = -1;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                dc = c;
                break;
            end
        end
        total++; if (dc != 25)           begin bad++; $display("FAIL b2b_latency got=%0d exp=25", dc); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL b2b_idle_done got=%b exp=0", done); end
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
        dc = -1;
        for (int c = 2; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                dc = c;
                break;
            end
        end
        total++; if (dc != 25)           begin bad++; $display("FAIL b2b_second_latency got=%0d exp=25", dc); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL b2b_second_pass got=%b exp=1", pass); end
        @(posedge clk); #1;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        fault  = 0;
        total  = 0;
        bad    = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_clean();
        test_and_stuck();
        test_not_wired();
        test_saturate();
        test_reset_mid();
        test_restart_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
